score_seven_seg: RTL and testbench
==================================

# score_seven_seg

Drives the board's 4-digit common-anode seven-segment display from the two BCD score digits produced by the score counter. It sits directly downstream of `score_and_display`, consuming `score0`, `score1` and `dis_score`. It time-multiplexes the digits, blanks a leading zero, and flashes the display for a fixed interval after every score increment.

## Interface
- `SCAN_PERIOD`, default 100000: clock cycles each digit stays selected (1 ms at 100 MHz).
- `FLASH_HALF`, default 25000000: clock cycles per on/off phase while flashing.
- `FLASH_TOGGLES`, default 6: phase toggles per flash episode (even, so the display ends lit).
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `score0`  in  4  BCD units digit.
- `score1`  in  4  BCD tens digit.
- `dis_score`  in  1  display enable; low = all digits dark and flash cancelled.
- `an`  out  4  anode selects, active-low, `an[0]` = rightmost digit.
- `seg`  out  7  cathodes `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal point, active-low; constant 1 (off).

## Operation
- Scan counter `scan_cnt` counts 0..`SCAN_PERIOD`-1 and wraps. On each wrap, the 2-bit `digit_idx` increments mod 4.
- Digit map: idx0 = `score0`; idx1 = `score1`; idx2 and idx3 are always blank (anode held high). All four slots are still scanned, so duty cycle and brightness are the same in every slot.
- Leading-zero blanking: idx1 is dark when `score1` == 0.
- Decode: 0-9 use standard glyphs. Any code from 10 to 15 shows `-` (segment g only, `seg`=7'b0111111). Examples: 0 = 7'b1000000, 1 = 7'b1111001, 7 = 7'b1111000.
- Change detector: register `{score1,score0}` into `prev` every cycle. If the new value differs from `prev` and the new value is nonzero, that is a score event. A transition to 00 (the counter clearing) is not an event.
- Flash FSM:
  - IDLE: display lit. On a score event, go to FLASH with `tog_cnt`=0, `phase_cnt`=0, `lit`=0.
  - FLASH: `phase_cnt` counts 0..`FLASH_HALF`-1. On wrap, `lit` toggles and `tog_cnt` increments. When `tog_cnt` reaches `FLASH_TOGGLES`, go to IDLE.
  - A score event while in FLASH restarts the episode: counters clear and `lit`=0.
- Blanking priority, highest first: `rst`, then `dis_score`=0, then FLASH with `lit`=0, then per-digit blanking.
- `dis_score`=0 forces the FSM to IDLE and updates `prev`, so re-enabling the display does not trigger a flash.

## Timing
- Reset values: `an`=4'b1111, `seg`=7'b1111111, `dp`=1, `scan_cnt`=0, `digit_idx`=0, FSM=IDLE, `prev`=8'h00.
- `an`, `seg` and `dp` are registered. They reflect `digit_idx`, the scores and the FSM state one cycle after those change.
- Score input to glyph visible: 1 cycle, once that digit is selected. The first dark phase starts 2 cycles after the score edge (detect cycle plus output register).
- In idx0's slot, `an`=4'b1110. In idx1's slot, `an`=4'b1101 when lit. In blank slots, `an`=4'b1111 and `seg`=7'b1111111.
- Slot changes happen on a single edge. `an` and `seg` update in the same cycle, with no overlap.
- Reset asserted mid-scan or mid-flash: every output takes its reset value on the next edge, and scanning restarts at idx0.
- A simultaneous score event and `dis_score` fall: `dis_score` wins, so no flash.

## Structure
- Shared package `score_disp_pkg` holds:
  - glyph constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_BLANK`;
  - `typedef enum {IDLE, FLASH} flash_state_t`;
  - `AN_OFF` = 4'b1111.
- One sub-module, `bcd_to_seg`: combinational, 4-bit BCD in, 7-bit active-low glyph out, codes 10-15 mapped to `SEG_DASH`.
- The top level holds the scan counter, digit mux, change detector, flash FSM and output registers.

## Test plan
Run all scenarios with `SCAN_PERIOD`=4, `FLASH_HALF`=8, `FLASH_TOGGLES`=6.
- Reset: hold `rst` 3 cycles with any inputs -> `an`=1111, `seg`=1111111, `dp`=1. After release, the first slot is idx0.
- Static 07: scores 0/7, `dis_score`=1 -> idx0 slot shows `seg`=1111000 on `an`=1110. The idx1 slot is dark (leading zero). Slots repeat every 16 cycles.
- Static 42: -> idx1 slot shows `an`=1101 with glyph 4 (`seg`=0011001); idx0 shows glyph 2 (`seg`=0100100).
- Increment 09 -> 10 -> display dark 2 cycles after the edge, then 6 phases of 8 cycles (dark/lit alternating), ending lit. Return to IDLE after 48 cycles.
- Events and enable:
  - A second increment mid-flash restarts the 48-cycle episode.
  - Clearing to 00 causes no flash.
  - `dis_score`=0 -> `an`=1111 within 1 cycle and the flash is cancelled.
- Invalid BCD: `score0`=12 -> idx0 shows `seg`=0111111. `rst` pulse mid-flash -> reset outputs next cycle and FSM in IDLE.

Source files
------------

// File: rtl/score_disp_pkg.sv
// Shared constants for the score display: active-low glyphs {g,f,e,d,c,b,a},
// anode-off pattern and the flash FSM state type.
package score_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment glyph; non-BCD codes show a dash.
module bcd_to_seg
  import score_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_seven_seg.sv
// Four-digit multiplexed score display with leading-zero blanking and a
// flash episode after every score increment.
//
//   state | meaning
//   IDLE  | display lit, waiting for a score event
//   FLASH | alternating dark/lit phases, lit_q selects the current phase
module score_seven_seg
  import score_disp_pkg::*;
#(
  parameter int unsigned SCAN_PERIOD   = 100000,
  parameter int unsigned FLASH_HALF    = 25000000,
  parameter int unsigned FLASH_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] score0,
  input  logic [3:0] score1,
  input  logic       dis_score,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned SCAN_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int unsigned PH_W   = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int unsigned TOG_W  = $clog2(FLASH_TOGGLES + 1);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(FLASH_HALF - 1);
  localparam logic [TOG_W-1:0]  TOG_LAST  = TOG_W'(FLASH_TOGGLES - 1);

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]        digit_idx_q, digit_idx_d;
  logic [7:0]        prev_q;
  flash_state_t      state_q, state_d;
  logic [PH_W-1:0]   phase_cnt_q, phase_cnt_d;
  logic [TOG_W-1:0]  tog_cnt_q, tog_cnt_d;
  logic              lit_q, lit_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q;

  logic [7:0] score_cat;
  logic       score_event;
  logic [3:0] digit_bcd;
  logic [6:0] digit_glyph;

  assign score_cat   = {score1, score0};
  assign score_event = (score_cat != prev_q) && (score_cat != 8'h00);
  assign digit_bcd   = digit_idx_q[0] ? score1 : score0;

  bcd_to_seg u_bcd_to_seg (
    .bcd_i (digit_bcd),
    .seg_o (digit_glyph)
  );

  always_comb begin
    scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
    digit_idx_d = digit_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d  = '0;
      digit_idx_d = digit_idx_q + 2'd1;
    end
  end

  // A disabled display cancels any flash; it outranks a simultaneous event.
  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    tog_cnt_d   = tog_cnt_q;
    lit_d       = lit_q;
    if (!dis_score) begin
      state_d     = IDLE;
      phase_cnt_d = '0;
      tog_cnt_d   = '0;
      lit_d       = 1'b1;
    end else if (score_event) begin
      state_d     = FLASH;
      phase_cnt_d = '0;
      tog_cnt_d   = '0;
      lit_d       = 1'b0;
    end else if (state_q == FLASH) begin
      if (phase_cnt_q == PH_LAST) begin
        phase_cnt_d = '0;
        lit_d       = ~lit_q;
        tog_cnt_d   = tog_cnt_q + TOG_W'(1);
        if (tog_cnt_q == TOG_LAST) begin
          state_d = IDLE;
        end
      end else begin
        phase_cnt_d = phase_cnt_q + PH_W'(1);
      end
    end
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    if (dis_score && !((state_q == FLASH) && !lit_q)) begin
      case (digit_idx_q)
        2'd0: begin
          an_d  = 4'b1110;
          seg_d = digit_glyph;
        end
        2'd1: begin
          if (score1 != 4'd0) begin
            an_d  = 4'b1101;
            seg_d = digit_glyph;
          end
        end
        default: begin
          an_d  = AN_OFF;
          seg_d = SEG_BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
      prev_q      <= 8'h00;
      state_q     <= IDLE;
      phase_cnt_q <= '0;
      tog_cnt_q   <= '0;
      lit_q       <= 1'b1;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      prev_q      <= score_cat;
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      tog_cnt_q   <= tog_cnt_d;
      lit_q       <= lit_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= 1'b1;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_score_seven_seg.sv
// Self-checking bench for score_seven_seg: elapsed-time reference model checked
// every cycle, plus literal spot checks and randomized score/enable/reset traffic.
module tb_score_seven_seg;

  localparam int SP        = 4;
  localparam int FH        = 8;
  localparam int FT        = 6;
  localparam int FLASH_LEN = FH * FT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] score0 = 4'd0;
  logic [3:0] score1 = 4'd0;
  logic       dis_score = 1'b1;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  score_seven_seg #(
    .SCAN_PERIOD   (SP),
    .FLASH_HALF    (FH),
    .FLASH_TOGGLES (FT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .score0    (score0),
    .score1    (score1),
    .dis_score (dis_score),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16];
  initial begin
    glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100;
    glyph[3] = 7'b0110000; glyph[4] = 7'b0011001; glyph[5] = 7'b0010010;
    glyph[6] = 7'b0000010; glyph[7] = 7'b1111000; glyph[8] = 7'b0000000;
    glyph[9] = 7'b0010000;
    for (int g = 10; g < 16; g++) glyph[g] = 7'b0111111;
  end

  // Reference: k = edges since reset release, ev_k = edge the latest flash began.
  int         k;
  int         ev_k;
  bit         fl_act;
  logic [7:0] prev_m;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  bit         model_valid = 1'b0;

  always @(posedge clk) begin : model
    int slot;
    int el;
    bit dark;
    if (rst) begin
      k           = 0;
      fl_act      = 1'b0;
      prev_m      = 8'h00;
      exp_an      = 4'b1111;
      exp_seg     = 7'b1111111;
      model_valid = 1'b1;
    end else begin
      slot    = (k / SP) % 4;
      el      = k - ev_k - 1;
      dark    = fl_act && (el < FLASH_LEN) && (((el / FH) % 2) == 0);
      exp_an  = 4'b1111;
      exp_seg = 7'b1111111;
      if (dis_score && !dark) begin
        if (slot == 0) begin
          exp_an  = 4'b1110;
          exp_seg = glyph[score0];
        end else if (slot == 1 && score1 != 4'd0) begin
          exp_an  = 4'b1101;
          exp_seg = glyph[score1];
        end
      end
      if (!dis_score) begin
        fl_act = 1'b0;
      end else if ({score1, score0} != prev_m && {score1, score0} != 8'h00) begin
        fl_act = 1'b1;
        ev_k   = k;
      end
      prev_m = {score1, score0};
      k++;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1",
                 $time, an, seg, dp, exp_an, exp_seg);
      end
    end
  end

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp_v);
    end
  endtask

  task automatic wait_an(input logic [3:0] target, input string name);
    int n;
    n = 0;
    while (an !== target && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (an !== target) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for an=%b, got %b", name, target, an);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int r;
    int v;
    rst       = 1'b1;
    score0    = 4'($urandom_range(0, 15));
    score1    = 4'($urandom_range(0, 15));
    dis_score = 1'($urandom_range(0, 1));
    idle(3);
    chk("reset_an", 7'(an), 7'h0F);
    chk("reset_seg", seg, 7'b1111111);
    chk("reset_dp", 7'(dp), 7'h01);

    rst = 1'b0; score1 = 4'd0; score0 = 4'd7; dis_score = 1'b1;
    idle(1);
    chk("first_slot_an", 7'(an), 7'h0E);
    chk("first_slot_seg7", seg, 7'b1111000);
    idle(1);
    chk("flash_dark_an", 7'(an), 7'h0F);
    idle(60);
    wait_an(4'b1110, "wait_07");
    chk("static07_seg", seg, 7'b1111000);

    score1 = 4'd4; score0 = 4'd2;
    idle(60);
    wait_an(4'b1101, "wait_42_tens");
    chk("static42_tens", seg, 7'b0011001);
    wait_an(4'b1110, "wait_42_units");
    chk("static42_units", seg, 7'b0100100);

    score1 = 4'd0; score0 = 4'd9;
    idle(60);
    score1 = 4'd1; score0 = 4'd0;
    idle(2);
    chk("inc_dark_an", 7'(an), 7'h0F);
    chk("inc_dark_seg", seg, 7'b1111111);
    idle(20);
    score0 = 4'd1;
    idle(30);
    score1 = 4'd0; score0 = 4'd0;
    idle(60);
    wait_an(4'b1110, "wait_00");
    chk("cleared_zero_seg", seg, 7'b1000000);

    score0 = 4'd5;
    idle(4);
    dis_score = 1'b0;
    idle(1);
    chk("disable_an", 7'(an), 7'h0F);
    idle(5);
    dis_score = 1'b1;
    idle(30);

    score0 = 4'd12;
    idle(60);
    wait_an(4'b1110, "wait_invalid");
    chk("invalid_dash", seg, 7'b0111111);

    score0 = 4'd3;
    idle(10);
    rst = 1'b1;
    idle(1);
    chk("rst_mid_an", 7'(an), 7'h0F);
    chk("rst_mid_seg", seg, 7'b1111111);
    rst = 1'b0;
    idle(1);
    chk("rst_restart_idx0", 7'(an), 7'h0E);
    idle(60);

    for (int i = 0; i < 3000; i++) begin
      r   = $urandom_range(0, 99);
      rst = 1'b0;
      if (r < 3) begin
        score0 = 4'($urandom_range(0, 15));
        score1 = 4'($urandom_range(0, 15));
      end else if (r < 7 && score0 < 4'd10 && score1 < 4'd10) begin
        v      = (int'(score1) * 10 + int'(score0) + 1) % 100;
        score1 = 4'(v / 10);
        score0 = 4'(v % 10);
      end else if (r == 7) begin
        score0 = 4'd0;
        score1 = 4'd0;
      end else if (r == 8) begin
        dis_score = ~dis_score;
      end else if (r == 9 && $urandom_range(0, 3) == 0) begin
        rst = 1'b1;
      end
      idle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
